// File: rtl/sm_rule_unpacker_pkg.sv
// sm_rule_pkg: shared widths, rule/flit types and FSM states for the rule unpacker
package sm_rule_pkg;
    localparam int RULE_W = 16;
    localparam int DATA_W = 512;
    localparam int META_W = 512;
    localparam int SLOTS  = DATA_W / RULE_W;
    localparam int IDX_W  = $clog2(SLOTS);
    typedef logic [RULE_W-1:0] rule_t;
    typedef rule_t [SLOTS-1:0] rule_flit_t;
    typedef enum logic [1:0] {WAIT_META, LOAD, SCAN, EMIT_META} state_t;
endpackage

// File: rtl/sm_rule_unpacker_if.sv
// sm_rule_unpacker_if: usr/meta input streams and rule/meta output streams
interface sm_rule_unpacker_if;
    import sm_rule_pkg::*;
    logic              in_usr_sop;
    logic              in_usr_eop;
    logic [DATA_W-1:0] in_usr_data;
    logic [5:0]        in_usr_empty;
    logic              in_usr_valid;
    logic              in_usr_ready;
    logic              in_meta_valid;
    logic              in_meta_ready;
    logic [META_W-1:0] in_meta_data;
    logic              out_rule_valid;
    logic              out_rule_ready;
    rule_t             out_rule_data;
    logic              out_rule_last;
    logic              out_meta_valid;
    logic              out_meta_ready;
    logic [META_W-1:0] out_meta_data;
    logic [15:0]       out_meta_rule_cnt;
    modport slave (
        input  in_usr_sop, in_usr_eop, in_usr_data, in_usr_empty, in_usr_valid,
        input  in_meta_valid, in_meta_data, out_rule_ready, out_meta_ready,
        output in_usr_ready, in_meta_ready, out_rule_valid, out_rule_data, out_rule_last,
        output out_meta_valid, out_meta_data, out_meta_rule_cnt
    );
    modport master (
        output in_usr_sop, in_usr_eop, in_usr_data, in_usr_empty, in_usr_valid,
        output in_meta_valid, in_meta_data, out_rule_ready, out_meta_ready,
        input  in_usr_ready, in_meta_ready, out_rule_valid, out_rule_data, out_rule_last,
        input  out_meta_valid, out_meta_data, out_meta_rule_cnt
    );
endinterface

// File: rtl/sm_rule_unpacker_slot_pe.sv
// sm_rule_slot_pe: lowest-set-slot priority encoder with any/onehot flags
module sm_rule_slot_pe
    import sm_rule_pkg::*;
(
    input  logic [SLOTS-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot
);
    always_comb begin
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (mask[i]) idx = IDX_W'(i);
    end
    assign any    = |mask;
    assign onehot = any && ((mask & (mask - SLOTS'(1))) == '0);
endmodule

// File: rtl/sm_rule_unpacker.sv
// sm_rule_unpacker: unpacks nonzero rule IDs from usr flits, then emits meta tagged with the rule count
module sm_rule_unpacker
    import sm_rule_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sm_rule_unpacker_if.slave  bus,
    output logic [31:0]        stats_rule,
    output logic [31:0]        stats_pkt
);
    state_t            state, state_nxt;
    rule_flit_t        flit, in_flit;
    logic              eop;
    logic [SLOTS-1:0]  mask, load_mask, mask_nxt;
    logic [META_W-1:0] meta;
    logic [15:0]       rule_cnt;
    logic [IDX_W-1:0]  idx;
    logic              any, onehot;
    logic [6:0]        lim;
    logic              rule_hs, usr_hs, meta_in_hs, meta_out_hs;

    sm_rule_slot_pe pe (.mask(mask), .idx(idx), .any(any), .onehot(onehot));

    // Slot s lives at the top end of the flit, so slot s is flit element SLOTS-1-s
    assign in_flit = bus.in_usr_data;
    assign lim     = (7'd64 - {1'b0, bus.in_usr_eop ? bus.in_usr_empty : 6'd0}) >> 1;
    always_comb begin
        load_mask = '0;
        for (int s = 0; s < SLOTS; s++)
            load_mask[s] = (7'(s) < lim) && (in_flit[SLOTS-1-s] != '0);
    end

    assign bus.in_meta_ready     = !rst && state == WAIT_META;
    assign bus.in_usr_ready      = !rst && state == LOAD;
    assign bus.out_rule_valid    = !rst && state == SCAN && any;
    assign bus.out_rule_data     = flit[~idx];
    assign bus.out_rule_last     = bus.out_rule_valid && onehot && eop;
    assign bus.out_meta_valid    = !rst && state == EMIT_META;
    assign bus.out_meta_data     = meta;
    assign bus.out_meta_rule_cnt = rule_cnt;

    assign rule_hs     = bus.out_rule_valid && bus.out_rule_ready;
    assign usr_hs      = bus.in_usr_valid && bus.in_usr_ready;
    assign meta_in_hs  = bus.in_meta_valid && bus.in_meta_ready;
    assign meta_out_hs = bus.out_meta_valid && bus.out_meta_ready;
    assign mask_nxt    = rule_hs ? mask & ~(SLOTS'(1) << idx) : mask;

    // An empty slot mask skips SCAN entirely so zero-rule flits cost no cycles
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_META: state_nxt = meta_in_hs ? LOAD : WAIT_META;
            LOAD:      state_nxt = !usr_hs ? LOAD : load_mask != '0 ? SCAN : bus.in_usr_eop ? EMIT_META : LOAD;
            SCAN:      state_nxt = mask_nxt != '0 ? SCAN : eop ? EMIT_META : LOAD;
            EMIT_META: state_nxt = meta_out_hs ? WAIT_META : EMIT_META;
            default:   state_nxt = WAIT_META;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_META;
            flit       <= '0;
            eop        <= 1'b0;
            mask       <= '0;
            meta       <= '0;
            rule_cnt   <= '0;
            stats_rule <= '0;
            stats_pkt  <= '0;
        end else begin
            state      <= state_nxt;
            mask       <= usr_hs ? load_mask : mask_nxt;
            stats_rule <= stats_rule + 32'(rule_hs);
            stats_pkt  <= stats_pkt + 32'(meta_out_hs);
            if (usr_hs) begin
                flit <= in_flit;
                eop  <= bus.in_usr_eop;
            end
            if (meta_in_hs) begin
                meta     <= bus.in_meta_data;
                rule_cnt <= '0;
            end else if (rule_hs) begin
                rule_cnt <= rule_cnt + 16'(rule_cnt != 16'hFFFF);
            end
        end
    end
endmodule
